// File: rtl/frame_sync_pkg.sv
// Shared state encoding, default sync pattern and sizing helpers for the serial frame synchroniser.
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [4:0] SYNC_PAT_DEF = 5'h1c;

    function automatic int frame_bits(input int sync_w, input int words_pf, input int word_w);
        return sync_w + words_pf * word_w;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_sync_bit_counter.sv
// Frame slot counter: slot 0 is the first payload bit after a sync, slot FRAME-1 the last bit of the next sync.
module frame_bit_counter
    import frame_sync_pkg::*;
#(
    parameter int FRAME    = 25,
    parameter int PAY_BITS = 20,
    parameter int WORD_W   = 5,
    parameter int SLOT_W   = 5
) (
    input  logic ClkIn,
    input  logic ClrIn,
    input  logic i_ena,
    input  logic i_clr,
    output logic o_word_end,
    output logic o_sync_end
);

    localparam int BIT_W = cnt_w(WORD_W);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME - 1);
    localparam logic [SLOT_W-1:0] PAY_V     = SLOT_W'(PAY_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);

    logic [SLOT_W-1:0] r_slot;
    logic [BIT_W-1:0]  r_bit;
    logic              w_in_pay;

    assign w_in_pay   = (r_slot < PAY_V);
    assign o_word_end = w_in_pay && (r_bit == BIT_LAST);
    assign o_sync_end = (r_slot == SLOT_LAST);

    // r_bit tracks the position inside the current payload word and rests at 0 across the sync field.
    always_ff @(posedge ClkIn or posedge ClrIn) begin
        if (ClrIn) begin
            r_slot <= '0;
            r_bit  <= '0;
        end else if (i_ena) begin
            if (i_clr || o_sync_end) begin
                r_slot <= '0;
                r_bit  <= '0;
            end else begin
                r_slot <= r_slot + 1'b1;
                r_bit  <= (w_in_pay && (r_bit != BIT_LAST)) ? r_bit + 1'b1 : '0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_sync.sv
// Serial frame synchroniser: hunts for the sync word, confirms alignment, deframes payload words
// and flywheels through isolated sync misses while locked.
module serial_frame_sync
    import frame_sync_pkg::*;
#(
    parameter int                SYNC_W   = 5,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEF),
    parameter int                WORD_W   = 5,
    parameter int                WORDS_PF = 4,
    parameter int                LOCK_CNT = 2,
    parameter int                LOSS_CNT = 2
) (
    input  logic              ClkIn,
    input  logic              ClrIn,
    input  logic              BitIn,
    input  logic              BitEna,
    output logic [WORD_W-1:0] WordOut,
    output logic              WordValid,
    output logic              Locked,
    output logic              SyncErr,
    output logic [7:0]        FrameCnt
);

    localparam int FRAME    = frame_bits(SYNC_W, WORDS_PF, WORD_W);
    localparam int PAY_BITS = WORDS_PF * WORD_W;
    localparam int SLOT_W   = cnt_w(FRAME);
    localparam int FILL_W   = cnt_w(SYNC_W + 1);
    localparam int GOOD_W   = cnt_w(LOCK_CNT + 1);
    localparam int MISS_W   = cnt_w(LOSS_CNT + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
    localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(SYNC_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_LIM  = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(LOSS_CNT);

    state_t              r_state, w_state_nxt;
    logic [SYNC_W-2:0]   r_win;
    logic [FILL_W-1:0]   r_fill;
    logic [GOOD_W-1:0]   r_good, w_good_nxt;
    logic [MISS_W-1:0]   r_miss, w_miss_nxt;
    logic [WORD_W-2:0]   r_word;
    logic [WORD_W-1:0]   r_word_out;
    logic                r_word_valid, r_locked, r_sync_err;
    logic [7:0]          r_frame_cnt;

    logic [SYNC_W-1:0]   w_win;
    logic [WORD_W-1:0]   w_word;
    logic                w_match, w_word_end, w_sync_end;
    logic                w_clr_slot, w_sync_err, w_frame_inc;

    // The window compare includes the bit arriving this cycle.
    assign w_win   = {r_win, BitIn};
    assign w_word  = {r_word, BitIn};
    assign w_match = (w_win == SYNC_PAT) && (r_fill >= FILL_THR);

    frame_bit_counter #(
        .FRAME    (FRAME),
        .PAY_BITS (PAY_BITS),
        .WORD_W   (WORD_W),
        .SLOT_W   (SLOT_W)
    ) u_slot (
        .ClkIn      (ClkIn),
        .ClrIn      (ClrIn),
        .i_ena      (BitEna),
        .i_clr      (w_clr_slot),
        .o_word_end (w_word_end),
        .o_sync_end (w_sync_end)
    );

    always_ff @(posedge ClkIn or posedge ClrIn) begin
        if (ClrIn) r_state <= HUNT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_clr_slot  = 1'b0;
        w_sync_err  = 1'b0;
        w_frame_inc = 1'b0;
        if (BitEna) begin
            case (r_state)
                HUNT: begin
                    if (w_match) begin
                        w_state_nxt = CONFIRM;
                        w_clr_slot  = 1'b1;
                        w_good_nxt  = '0;
                    end
                end
                CONFIRM: begin
                    if (w_sync_end) begin
                        if (w_match) begin
                            w_good_nxt = r_good + 1'b1;
                            if (w_good_nxt == GOOD_LIM) begin
                                w_state_nxt = LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            w_state_nxt = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (w_sync_end) begin
                        w_frame_inc = 1'b1;
                        if (w_match) begin
                            w_miss_nxt = '0;
                        end else begin
                            // Frame timing is kept; only repeated misses give up the lock.
                            w_sync_err = 1'b1;
                            w_miss_nxt = r_miss + 1'b1;
                            if (w_miss_nxt == MISS_LIM) w_state_nxt = HUNT;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge ClkIn or posedge ClrIn) begin
        if (ClrIn) begin
            r_win        <= '0;
            r_fill       <= '0;
            r_good       <= '0;
            r_miss       <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_word_valid <= 1'b0;
            r_sync_err   <= w_sync_err;
            r_good       <= w_good_nxt;
            r_miss       <= w_miss_nxt;
            r_locked     <= (w_state_nxt == LOCKED);
            if (BitEna) begin
                r_win <= w_win[SYNC_W-2:0];
                if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
                if ((r_state == LOCKED) && w_word_end) begin
                    r_word_out   <= w_word;
                    r_word_valid <= 1'b1;
                end
                if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Payload shifter carries data only, so it needs no reset.
    always_ff @(posedge ClkIn) begin
        if (BitEna) r_word <= w_word[WORD_W-2:0];
    end

    assign WordOut   = r_word_out;
    assign WordValid = r_word_valid;
    assign Locked    = r_locked;
    assign SyncErr   = r_sync_err;
    assign FrameCnt  = r_frame_cnt;

endmodule

// File: tb/tb_serial_frame_sync.sv
// Scoreboard bench for serial_frame_sync: expected words queued as payload is driven, compared per test.
module tb_serial_frame_sync;

    logic       ClkIn = 1'b0;
    logic       ClrIn = 1'b1;
    logic       BitIn = 1'b0;
    logic       BitEna = 1'b0;
    logic [4:0] WordOut;
    logic       WordValid, Locked, SyncErr;
    logic [7:0] FrameCnt;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    int         obs_rd = 0;
    int         serr_cnt = 0;
    logic [4:0] pay [4] = '{5'h05, 5'h0a, 5'h15, 5'h1f};

    serial_frame_sync dut (
        .ClkIn     (ClkIn),
        .ClrIn     (ClrIn),
        .BitIn     (BitIn),
        .BitEna    (BitEna),
        .WordOut   (WordOut),
        .WordValid (WordValid),
        .Locked    (Locked),
        .SyncErr   (SyncErr),
        .FrameCnt  (FrameCnt)
    );

    always #5 ClkIn = ~ClkIn;

    always @(negedge ClkIn) begin
        if (WordValid) obs_q.push_back(WordOut);
        if (SyncErr) serr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic b);
        @(negedge ClkIn);
        BitIn  = b;
        BitEna = 1'b1;
        @(posedge ClkIn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ClkIn);
            BitEna = 1'b0;
            BitIn  = 1'b0;
        end
    endtask

    task automatic send_sync(input logic [4:0] p);
        for (int i = 4; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic send_pay_range(input bit expect_out, input int first, input int last);
        logic [4:0] w;
        for (int i = first; i <= last; i++) begin
            w = pay[i / 5];
            if (expect_out && (i % 5 == 4)) exp_q.push_back(w);
            send_bit(w[4 - (i % 5)]);
        end
    endtask

    task automatic do_reset();
        @(negedge ClkIn);
        ClrIn  = 1'b1;
        BitEna = 1'b0;
        BitIn  = 1'b0;
        idle(2);
        ClrIn = 1'b0;
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic acquire();
        send_sync(5'h1c); send_pay_range(0, 0, 19);
        send_sync(5'h1c); send_pay_range(0, 0, 19);
        send_sync(5'h1c);
    endtask

    task automatic test_reset();
        @(negedge ClkIn);
        ClrIn = 1'b1;
        #1;
        total++; if (WordOut !== 5'h00)  begin bad++; $display("FAIL rst_wordout got=%h want=00", WordOut); end
        total++; if (WordValid !== 1'b0) begin bad++; $display("FAIL rst_wordvalid got=%b want=0", WordValid); end
        total++; if (Locked !== 1'b0)    begin bad++; $display("FAIL rst_locked got=%b want=0", Locked); end
        total++; if (SyncErr !== 1'b0)   begin bad++; $display("FAIL rst_syncerr got=%b want=0", SyncErr); end
        total++; if (FrameCnt !== 8'd0)  begin bad++; $display("FAIL rst_framecnt got=%0d want=0", FrameCnt); end
        do_reset();
        send_sync(5'h00);
        idle(3);
        total++; if (Locked !== 1'b0) begin bad++; $display("FAIL zeros_locked got=%b want=0", Locked); end
        total++; if (obs_q.size() != obs_rd) begin bad++; $display("FAIL zeros_words got=%0d want=0", obs_q.size() - obs_rd); end
    endtask

    task automatic test_acquire();
        logic [4:0] e;
        do_reset();
        send_sync(5'h1c); send_pay_range(0, 0, 19);
        send_sync(5'h1c); #1;
        total++; if (Locked !== 1'b0) begin bad++; $display("FAIL acq_early_lock got=%b want=0", Locked); end
        send_pay_range(0, 0, 19);
        send_sync(5'h1c); #1;
        total++; if (Locked !== 1'b1) begin bad++; $display("FAIL acq_lock got=%b want=1", Locked); end
        send_pay_range(1, 0, 19);
        send_sync(5'h1c); #1;
        total++; if (FrameCnt !== 8'd1) begin bad++; $display("FAIL acq_framecnt got=%0d want=1", FrameCnt); end
        idle(3);
        total++;
        if (obs_q.size() - obs_rd != exp_q.size()) begin
            bad++; $display("FAIL acq_word_count got=%0d want=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                total++;
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL acq_word got=%h want=%h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_confirm_fail();
        do_reset();
        send_sync(5'h1c); send_pay_range(0, 0, 19);
        send_sync(5'h1d);
        send_pay_range(0, 0, 19);
        send_sync(5'h1d);
        idle(3);
        total++; if (Locked !== 1'b0) begin bad++; $display("FAIL cfail_locked got=%b want=0", Locked); end
        total++; if (obs_q.size() != obs_rd) begin bad++; $display("FAIL cfail_words got=%0d want=0", obs_q.size() - obs_rd); end
        total++; if (FrameCnt !== 8'd0) begin bad++; $display("FAIL cfail_framecnt got=%0d want=0", FrameCnt); end
    endtask

    task automatic test_flywheel();
        logic [4:0] e;
        int serr0;
        do_reset();
        acquire();
        serr0 = serr_cnt;
        send_pay_range(1, 0, 19);
        send_sync(5'h00); #1;
        total++; if (SyncErr !== 1'b1)  begin bad++; $display("FAIL fly1_syncerr got=%b want=1", SyncErr); end
        total++; if (Locked !== 1'b1)   begin bad++; $display("FAIL fly1_locked got=%b want=1", Locked); end
        total++; if (FrameCnt !== 8'd1) begin bad++; $display("FAIL fly1_framecnt got=%0d want=1", FrameCnt); end
        idle(2);
        total++; if (SyncErr !== 1'b0)  begin bad++; $display("FAIL fly1_strobe got=%b want=0", SyncErr); end
        send_pay_range(1, 0, 19);
        send_sync(5'h0f); #1;
        total++; if (SyncErr !== 1'b1)  begin bad++; $display("FAIL fly2_syncerr got=%b want=1", SyncErr); end
        total++; if (Locked !== 1'b0)   begin bad++; $display("FAIL fly2_locked got=%b want=0", Locked); end
        total++; if (FrameCnt !== 8'd2) begin bad++; $display("FAIL fly2_framecnt got=%0d want=2", FrameCnt); end
        send_pay_range(0, 0, 19);
        idle(3);
        total++; if (serr_cnt - serr0 != 2) begin bad++; $display("FAIL fly_serr_pulses got=%0d want=2", serr_cnt - serr0); end
        total++;
        if (obs_q.size() - obs_rd != exp_q.size()) begin
            bad++; $display("FAIL fly_word_count got=%0d want=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                total++;
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL fly_word got=%h want=%h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_bitena_gap();
        logic [4:0] e;
        do_reset();
        acquire();
        send_pay_range(1, 0, 11);
        idle(7);
        total++; if (WordOut !== 5'h0a)  begin bad++; $display("FAIL gap_wordout got=%h want=0a", WordOut); end
        total++; if (WordValid !== 1'b0) begin bad++; $display("FAIL gap_wordvalid got=%b want=0", WordValid); end
        send_pay_range(1, 12, 19);
        send_sync(5'h1c); #1;
        total++; if (Locked !== 1'b1) begin bad++; $display("FAIL gap_locked got=%b want=1", Locked); end
        idle(3);
        total++;
        if (obs_q.size() - obs_rd != exp_q.size()) begin
            bad++; $display("FAIL gap_word_count got=%0d want=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                total++;
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL gap_word got=%h want=%h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0] e;
        do_reset();
        acquire();
        send_pay_range(1, 0, 19);
        send_sync(5'h1c); #1;
        total++; if (FrameCnt !== 8'd1) begin bad++; $display("FAIL mid_pre_framecnt got=%0d want=1", FrameCnt); end
        send_pay_range(1, 0, 11);
        @(negedge ClkIn);
        ClrIn  = 1'b1;
        BitEna = 1'b0;
        #1;
        total++; if (Locked !== 1'b0)    begin bad++; $display("FAIL mid_locked got=%b want=0", Locked); end
        total++; if (FrameCnt !== 8'd0)  begin bad++; $display("FAIL mid_framecnt got=%0d want=0", FrameCnt); end
        total++; if (WordValid !== 1'b0) begin bad++; $display("FAIL mid_wordvalid got=%b want=0", WordValid); end
        @(negedge ClkIn);
        ClrIn = 1'b0;
        acquire(); #1;
        total++; if (Locked !== 1'b1) begin bad++; $display("FAIL mid_relock got=%b want=1", Locked); end
        send_pay_range(1, 0, 19);
        send_sync(5'h1c); #1;
        total++; if (FrameCnt !== 8'd1) begin bad++; $display("FAIL mid_framecnt_re got=%0d want=1", FrameCnt); end
        idle(3);
        total++;
        if (obs_q.size() - obs_rd != exp_q.size()) begin
            bad++; $display("FAIL mid_word_count got=%0d want=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                total++;
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL mid_word got=%h want=%h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_confirm_fail();
        test_flywheel();
        test_bitena_gap();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
